ct_f_spsram_ctrl_4096x144: RTL

CT_F_SPSRAM_CTRL_4096X144 -- requirements
Module: ct_f_spsram_ctrl_4096x144

---
 rtl/ct_f_spsram_ctrl_4096x144.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ct_f_spsram_ctrl_4096x144.sv
// Single-port SRAM controller: zero-fills the array after reset, then issues
// masked writes and reads into a 2-entry in-order response FIFO.
module ct_f_spsram_ctrl_4096x144 #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 144,
  parameter bit INIT_EN    = 1'b1
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  typedef enum logic [1:0] {
    RST_WAIT = 2'd0,
    INIT     = 2'd1,
    RUN      = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] INIT_LAST = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  state_t                state_r;
  state_t                state_nxt_s;
  logic [ADDR_WIDTH-1:0] init_cnt_r;
  logic                  init_done_r;
  logic [1:0]            credit_r;
  logic                  rd_pend_r;
  logic [DATA_WIDTH-1:0] fifo0_r;
  logic [DATA_WIDTH-1:0] fifo1_r;
  logic                  wr_ptr_r;
  logic                  rd_ptr_r;
  logic [1:0]            fifo_cnt_r;
  logic                  rdy_s;
  logic                  rd_acc_s;
  logic                  rsp_pop_s;

  // Credit covers queued plus in-flight reads, so a read may also go when the head drains this cycle.
  assign rsp_vld   = (fifo_cnt_r != 2'd0);
  assign rsp_rdata = rd_ptr_r ? fifo1_r : fifo0_r;
  assign rsp_pop_s = rsp_vld & rsp_rdy;
  assign rdy_s     = (state_r == RUN) & (req_wr | (credit_r < 2'd2) | rsp_pop_s);
  assign rd_acc_s  = req_vld & rdy_s & ~req_wr;
  assign init_done = init_done_r;

  // FSM state register
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) state_r <= RST_WAIT;
    else           state_r <= state_nxt_s;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RST_WAIT: state_nxt_s = INIT_EN ? INIT : RUN;
      INIT: begin
        if (init_cnt_r == INIT_LAST) state_nxt_s = RUN;
        else                         state_nxt_s = INIT;
      end
      RUN:      state_nxt_s = RUN;
      default:  state_nxt_s = RST_WAIT;
    endcase
  end

  // FSM outputs: SRAM port and request handshake
  always_comb begin
    req_rdy   = 1'b0;
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = {DATA_WIDTH{1'b1}};
    sram_a    = req_addr;
    sram_d    = req_wdata;
    case (state_r)
      RST_WAIT: begin
        req_rdy = 1'b0;
      end
      INIT: begin
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_wen  = {DATA_WIDTH{1'b0}};
        sram_a    = init_cnt_r;
        sram_d    = {DATA_WIDTH{1'b0}};
      end
      RUN: begin
        req_rdy = rdy_s;
        if (req_vld & rdy_s) begin
          sram_cen  = 1'b0;
          sram_gwen = ~req_wr;
          sram_wen  = req_wr ? ~req_wmask : {DATA_WIDTH{1'b1}};
        end else begin
          sram_cen  = 1'b1;
          sram_gwen = 1'b1;
        end
      end
      default: begin
        req_rdy = 1'b0;
      end
    endcase
  end

  // Init address counter and registered init_done
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      init_cnt_r  <= {ADDR_WIDTH{1'b0}};
      init_done_r <= 1'b0;
    end else begin
      init_done_r <= (state_nxt_s == RUN);
      if ((state_r == INIT) && (init_cnt_r != INIT_LAST)) init_cnt_r <= init_cnt_r + ADDR_ONE;
    end
  end

  // Read credit bookkeeping
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      credit_r <= 2'd0;
    end else begin
      case ({rd_acc_s, rsp_pop_s})
        2'b10:   credit_r <= credit_r + 2'd1;
        2'b01:   credit_r <= credit_r - 2'd1;
        default: credit_r <= credit_r;
      endcase
    end
  end

  // Response FIFO: sram_q is captured the cycle after the read access
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rd_pend_r  <= 1'b0;
      fifo0_r    <= {DATA_WIDTH{1'b0}};
      fifo1_r    <= {DATA_WIDTH{1'b0}};
      wr_ptr_r   <= 1'b0;
      rd_ptr_r   <= 1'b0;
      fifo_cnt_r <= 2'd0;
    end else begin
      rd_pend_r <= rd_acc_s;
      if (rd_pend_r) begin
        if (wr_ptr_r) fifo1_r <= sram_q;
        else          fifo0_r <= sram_q;
        wr_ptr_r <= ~wr_ptr_r;
      end
      if (rsp_pop_s) rd_ptr_r <= ~rd_ptr_r;
      case ({rd_pend_r, rsp_pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + 2'd1;
        2'b01:   fifo_cnt_r <= fifo_cnt_r - 2'd1;
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

endmodule
